// File: rtl/reg_map_writer.sv
// Write-side initiator for the equaliser register map: turns one whole-register
// update (config byte or band gain) into a run of byte writes, LSB first.
module reg_map_writer #(
  parameter int GAIN_WIDTH = 24,
  parameter int NUM_BANDS  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_band,
  input  logic [GAIN_WIDTH-1:0] req_data,
  output logic                  reg_we,
  output logic [7:0]            reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  done,
  output logic                  err
);

  localparam int BYTES = GAIN_WIDTH / 8;
  localparam logic [4:0] MAX_BAND = 5'(NUM_BANDS);

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH} state_t;

  state_t                state_q;
  logic [GAIN_WIDTH-1:0] shift_q;
  logic [7:0]            left_q;
  logic                  we_q;
  logic [7:0]            addr_q;
  logic [7:0]            wdata_q;
  logic                  done_q;
  logic                  err_q;

  logic                  legal_d;
  logic [7:0]            base_d;
  logic [7:0]            left_d;
  logic                  single_d;

  // Decode the incoming request: legality, first byte address, bytes after the first.
  always_comb begin
    legal_d  = ({1'b0, req_band} <= MAX_BAND);
    base_d   = 8'd0;
    left_d   = 8'd0;
    single_d = 1'b1;
    if (req_band != 4'd0) begin
      base_d   = 8'(1 + (int'(req_band) - 1) * BYTES);
      left_d   = 8'(BYTES - 1);
      single_d = (BYTES == 1);
    end
  end

  assign req_ready = (state_q == IDLE);
  assign reg_we    = we_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      left_q  <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (legal_d) begin
              we_q    <= 1'b1;
              addr_q  <= base_d;
              wdata_q <= req_data[7:0];
              done_q  <= single_d;
              shift_q <= req_data >> 8;
              left_q  <= left_d;
              state_q <= WRITE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          // left_q counts bytes still to present after the one on the bus now.
          if (left_q == 8'd0) begin
            we_q    <= 1'b0;
            state_q <= FLUSH;
          end else begin
            addr_q  <= addr_q + 8'd1;
            wdata_q <= shift_q[7:0];
            shift_q <= shift_q >> 8;
            done_q  <= (left_q == 8'd1);
            left_q  <= left_q - 8'd1;
          end
        end
        FLUSH: begin
          state_q <= IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_map_writer.sv
// Randomised scoreboard bench for reg_map_writer: a request-level map model
// predicts every byte write and error pulse, a negedge monitor checks them.
module tb_reg_map_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_band = 4'd0;
  logic [23:0] req_data = 24'd0;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        done;
  logic        err;

  reg_map_writer #(.GAIN_WIDTH(24), .NUM_BANDS(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_band(req_band), .req_data(req_data), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
    int         cyc;
  } wr_t;

  wr_t        exp_q[$];
  int         err_q[$];
  logic [7:0] map_ref[0:30];
  logic [7:0] map_dut[0:30];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         prev_acc = -1;
  int         prev_gap = 0;
  wr_t        mon_e;
  int         mon_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe and error pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      if (reg_we) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write", reg_addr, reg_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", {24'd0, reg_addr}, {24'd0, mon_e.addr});
          chk("wr_data", {24'd0, reg_wdata}, {24'd0, mon_e.data});
          chk("wr_done", {31'd0, done}, {31'd0, mon_e.last});
          chk("wr_cycle", cyc, mon_e.cyc);
          chk("ready_busy", {31'd0, req_ready}, 32'd0);
        end
        if (reg_addr <= 8'd30) map_dut[reg_addr] = reg_wdata;
      end else if (done) begin
        tests++; fails++;
        $display("FAIL done_without_we: got done 1 expected 0");
      end
      if (err) begin
        if (err_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_err: got err 1 expected 0");
        end else begin
          mon_c = err_q.pop_front();
          chk("err_cycle", cyc, mon_c);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [3:0] band, input logic [23:0] data, input bit chk_gap);
    int w;
    int acc;
    int n;
    int base;
    w = 0;
    req_valid = 1'b1;
    req_band  = band;
    req_data  = data;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL handshake_timeout: got ready 0 expected 1 within 20 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (chk_gap && prev_acc >= 0) chk("accept_gap", acc - prev_acc, prev_gap);
    if (band > 4'd10) begin
      err_q.push_back(acc);
      prev_gap = 1;
    end else begin
      n    = (band == 4'd0) ? 1 : 3;
      base = (band == 4'd0) ? 0 : 1 + (int'(band) - 1) * 3;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back('{addr: 8'(base + k), data: data[8*k +: 8], last: (k == n - 1), cyc: acc + k});
        map_ref[base + k] = data[8*k +: 8];
      end
      prev_gap = n + 2;
    end
    prev_acc = acc;
    @(negedge clk);
  endtask

  task automatic go_idle(input int cycles);
    req_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit held;
    for (int i = 0; i < 31; i++) begin
      map_ref[i] = 8'd0;
      map_dut[i] = 8'd0;
    end

    // Reset held with valid high: nothing may move.
    req_valid = 1'b1;
    req_band  = 4'd2;
    req_data  = 24'h123456;
    repeat (2) begin
      @(negedge clk);
      chk("rst_we", {31'd0, reg_we}, 32'd0);
      chk("rst_addr", {24'd0, reg_addr}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
    end
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    // Config write then a gain write back-to-back (config turnaround is 3).
    send(4'd0, 24'h5555AA, 1'b0);
    send(4'd2, 24'h1C71C7, 1'b1);
    go_idle(6);
    chk("map_cfg", {24'd0, map_dut[0]}, 32'h0000AA);
    chk("map_gain2", {8'd0, map_dut[6], map_dut[5], map_dut[4]}, 32'h1C71C7);

    // Full sweep, valid held high throughout.
    for (int b = 1; b <= 10; b++) send(4'(b), 24'((b - 1) * 24'h1C71C7), (b > 1));
    go_idle(6);
    chk("map_gain10", {8'd0, map_dut[30], map_dut[29], map_dut[28]}, 32'hFFFFFF);
    chk("map_gain1", {8'd0, map_dut[3], map_dut[2], map_dut[1]}, 32'h000000);

    // Illegal bands are accepted immediately and flag err.
    send(4'd11, 24'hDEAD01, 1'b0);
    send(4'd15, 24'hDEAD02, 1'b1);
    send(4'd3, 24'hA5C3E7, 1'b1);
    go_idle(6);

    // Randomised traffic with random idle gaps.
    held = 1'b0;
    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(0, 12)), 24'($urandom), held);
      if ($urandom_range(0, 2) == 0) begin
        go_idle($urandom_range(1, 3));
        held = 1'b0;
      end else begin
        held = 1'b1;
      end
    end
    go_idle(6);

    // Reset after the first byte of a gain write, then reissue.
    send(4'd5, 24'h71AB1E, 1'b0);
    req_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_we", {31'd0, reg_we}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(4'd5, 24'h71AB1E, 1'b0);
    go_idle(8);
    chk("map_gain5", {8'd0, map_dut[15], map_dut[14], map_dut[13]}, 32'h71AB1E);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("err_q_empty", err_q.size(), 32'd0);
    for (int i = 0; i < 31; i++) chk($sformatf("map_%0d", i), {24'd0, map_dut[i]}, {24'd0, map_ref[i]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
